// File: rtl/seq_recognizer_param.sv
// Programmable K-symbol sequence recognizer; z pulses the cycle after the final symbol is sampled.
// One-cycle latency, no backpressure: each en-qualified symbol is consumed at its posedge.
module seq_recognizer_param #(
  parameter int             N        = 2,
  parameter int             K        = 3,
  parameter int             CW       = 8,
  parameter logic [N*K-1:0] INIT_SEQ = 6'b10_01_11,
  parameter bit             INIT_OVL = 1'b1
) (
  input  logic            clock,
  input  logic            reset_,
  input  logic [N-1:0]    x,
  input  logic            en,
  input  logic            cfg_load,
  input  logic [N*K-1:0]  cfg_seq,
  input  logic            cfg_ovl,
  output logic            z,
  output logic [CW-1:0]   mcount
);

  localparam int FW = $clog2(K);
  localparam logic [FW-1:0] FILL_MAX = FW'(K-1);

  logic [N*K-1:0]          r_pat;
  logic                    r_ovl;
  logic [K-2:0][N-1:0]     r_hist;
  logic [FW-1:0]           r_fill;
  logic                    r_z;
  logic [CW-1:0]           r_mcount;

  logic                    w_hist_ok;
  logic                    w_hit;
  logic [K-2:0][N-1:0]     w_hist_nxt;
  logic [FW-1:0]           w_fill_nxt;

  // History slot j holds the symbol accepted j+1 samples before x, so it
  // must equal pattern symbol K-2-j for the window to match.
  always_comb begin
    w_hist_ok = 1'b1;
    for (int j = 0; j < K-1; j++) begin
      if (r_hist[j] != r_pat[N*(K-2-j) +: N]) w_hist_ok = 1'b0;
    end
  end

  assign w_hit = (r_fill == FILL_MAX) && (x == r_pat[N*(K-1) +: N]) && w_hist_ok;

  always_comb begin
    w_hist_nxt    = r_hist;
    w_hist_nxt[0] = x;
    for (int j = 1; j < K-1; j++) begin
      w_hist_nxt[j] = r_hist[j-1];
    end
  end

  // Non-overlapping mode restarts the fill so the next match needs K fresh symbols.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_hit && !r_ovl)
      w_fill_nxt = '0;
    else if (r_fill != FILL_MAX)
      w_fill_nxt = r_fill + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_pat    <= INIT_SEQ;
      r_ovl    <= INIT_OVL;
      r_hist   <= '0;
      r_fill   <= '0;
      r_z      <= 1'b0;
      r_mcount <= '0;
    end else if (cfg_load) begin
      r_pat    <= cfg_seq;
      r_ovl    <= cfg_ovl;
      r_hist   <= '0;
      r_fill   <= '0;
      r_z      <= 1'b0;
      r_mcount <= '0;
    end else if (en) begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_z    <= w_hit;
      if (w_hit && (r_mcount != {CW{1'b1}}))
        r_mcount <= r_mcount + 1'b1;
    end else begin
      r_z <= 1'b0;
    end
  end

  assign z      = r_z;
  assign mcount = r_mcount;

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Directed bench for seq_recognizer_param: default-width instance plus a CW=2 instance sharing stimulus.
module tb_seq_recognizer_param;

  logic       clock;
  logic       reset_;
  logic [1:0] x;
  logic       en;
  logic       cfg_load;
  logic [5:0] cfg_seq;
  logic       cfg_ovl;
  logic       z;
  logic [7:0] mcount;
  logic       z2;
  logic [1:0] mc2;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] DEF_SEQ = 6'b10_01_11;
  localparam logic [5:0] SEQ_01  = 6'b01_01_01;

  seq_recognizer_param dut (
    .clock(clock), .reset_(reset_), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_seq(cfg_seq), .cfg_ovl(cfg_ovl), .z(z), .mcount(mcount)
  );

  seq_recognizer_param #(.CW(2)) dut_c2 (
    .clock(clock), .reset_(reset_), .x(x), .en(en), .cfg_load(cfg_load),
    .cfg_seq(cfg_seq), .cfg_ovl(cfg_ovl), .z(z2), .mcount(mc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] xv, input logic ev);
    x  = xv;
    en = ev;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [5:0] seq, input logic ovl);
    cfg_load = 1'b1;
    cfg_seq  = seq;
    cfg_ovl  = ovl;
    en       = 1'b0;
    @(posedge clock);
    #1;
    cfg_load = 1'b0;
  endtask

  initial begin
    reset_   = 1'b0;
    x        = 2'b00;
    en       = 1'b0;
    cfg_load = 1'b0;
    cfg_seq  = DEF_SEQ;
    cfg_ovl  = 1'b1;
    #2;
    chk("rst_z", {7'd0, z}, 8'd0);
    chk("rst_mcount", mcount, 8'd0);
    chk("rst_mc2", {6'd0, mc2}, 8'd0);
    @(posedge clock);
    #1;
    reset_ = 1'b1;

    // Basic match 11,01,10
    tick(2'b11, 1'b1); chk("basic_s1_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("basic_s2_z", {7'd0, z}, 8'd0);
    tick(2'b10, 1'b1); chk("basic_hit_z", {7'd0, z}, 8'd1);
    chk("basic_mcount", mcount, 8'd1);
    tick(2'b00, 1'b0); chk("basic_pulse_end_z", {7'd0, z}, 8'd0);
    chk("idle_mcount_hold", mcount, 8'd1);

    // Fallback 11,11,01,10
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b1); chk("fb1_s2_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("fb1_s3_z", {7'd0, z}, 8'd0);
    tick(2'b10, 1'b1); chk("fb1_hit_z", {7'd0, z}, 8'd1);
    chk("fb1_mcount", mcount, 8'd2);

    // Fallback 11,01,11,01,10
    tick(2'b11, 1'b1);
    tick(2'b01, 1'b1);
    tick(2'b11, 1'b1); chk("fb2_s3_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("fb2_s4_z", {7'd0, z}, 8'd0);
    tick(2'b10, 1'b1); chk("fb2_hit_z", {7'd0, z}, 8'd1);
    chk("fb2_mcount", mcount, 8'd3);

    // Overlapping 01,01,01 with 5 samples
    load(SEQ_01, 1'b1);
    chk("load_clr_mcount", mcount, 8'd0);
    chk("load_clr_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("ovl_s1_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("ovl_s2_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("ovl_s3_z", {7'd0, z}, 8'd1);
    tick(2'b01, 1'b1); chk("ovl_s4_z", {7'd0, z}, 8'd1);
    tick(2'b01, 1'b1); chk("ovl_s5_z", {7'd0, z}, 8'd1);
    chk("ovl_mcount", mcount, 8'd3);
    tick(2'b01, 1'b0); chk("ovl_idle_z", {7'd0, z}, 8'd0);

    // Non-overlapping 01,01,01 with 6 samples
    load(SEQ_01, 1'b0);
    tick(2'b01, 1'b1); chk("novl_s1_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("novl_s2_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("novl_s3_z", {7'd0, z}, 8'd1);
    tick(2'b01, 1'b1); chk("novl_s4_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("novl_s5_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1); chk("novl_s6_z", {7'd0, z}, 8'd1);
    chk("novl_mcount", mcount, 8'd2);

    // Idle cycle inside a sequence does not break it
    load(DEF_SEQ, 1'b1);
    tick(2'b11, 1'b1);
    tick(2'b00, 1'b0); chk("gap_idle_z", {7'd0, z}, 8'd0);
    tick(2'b01, 1'b1);
    tick(2'b10, 1'b1); chk("gap_hit_z", {7'd0, z}, 8'd1);
    chk("gap_mcount", mcount, 8'd1);

    // cfg_load on the 01 cycle wipes the partial match
    load(DEF_SEQ, 1'b1);
    tick(2'b11, 1'b1);
    tick(2'b00, 1'b0);
    cfg_load = 1'b1;
    cfg_seq  = DEF_SEQ;
    cfg_ovl  = 1'b1;
    tick(2'b01, 1'b1);
    cfg_load = 1'b0;
    tick(2'b10, 1'b1); chk("ldmid_z", {7'd0, z}, 8'd0);
    chk("ldmid_mcount", mcount, 8'd0);

    // Saturation on the CW=2 instance
    for (int s = 1; s <= 5; s++) begin
      tick(2'b11, 1'b1);
      tick(2'b01, 1'b1);
      tick(2'b10, 1'b1);
      chk($sformatf("sat_z2_%0d", s), {7'd0, z2}, 8'd1);
      chk($sformatf("sat_mc2_%0d", s), {6'd0, mc2}, (s < 3) ? 8'(s) : 8'd3);
      chk($sformatf("sat_mc8_%0d", s), mcount, 8'(s));
    end

    // Asynchronous reset mid-sequence
    tick(2'b11, 1'b1);
    tick(2'b01, 1'b1);
    reset_ = 1'b0;
    #2;
    chk("arst_z", {7'd0, z}, 8'd0);
    chk("arst_mcount", mcount, 8'd0);
    chk("arst_mc2", {6'd0, mc2}, 8'd0);
    #3;
    reset_ = 1'b1;
    tick(2'b10, 1'b1); chk("arst_after_z", {7'd0, z}, 8'd0);
    chk("arst_after_mcount", mcount, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
